// File: rtl/riscv_mem_pkg.sv
// Load/store encodings, FSM state and owner types shared by the memory controller and the MEM stage.
package riscv_mem_pkg;

   localparam logic [2:0] LD_NONE = 3'd0;
   localparam logic [2:0] LD_LB   = 3'd1;
   localparam logic [2:0] LD_LH   = 3'd2;
   localparam logic [2:0] LD_LW   = 3'd3;
   localparam logic [2:0] LD_LBU  = 3'd4;
   localparam logic [2:0] LD_LHU  = 3'd5;

   localparam logic [1:0] ST_NONE = 2'd0;
   localparam logic [1:0] ST_SB   = 2'd1;
   localparam logic [1:0] ST_SH   = 2'd2;
   localparam logic [1:0] ST_SW   = 2'd3;

   typedef enum logic [1:0] {S_IDLE, S_XFER, S_WAIT, S_DONE} mem_state_t;
   typedef enum logic {OWN_IF, OWN_DATA} mem_owner_t;

   // Index of the last byte transferred (N-1) for a given access type.
   function automatic logic [1:0] ld_last(input logic [2:0] ld);
      case (ld)
         LD_LH, LD_LHU: ld_last = 2'd1;
         LD_LW:         ld_last = 2'd3;
         default:       ld_last = 2'd0;
      endcase
   endfunction

   function automatic logic [1:0] st_last(input logic [1:0] st);
      case (st)
         ST_SH:   st_last = 2'd1;
         ST_SW:   st_last = 2'd3;
         default: st_last = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/mem_ld_extend.sv
// Sign/zero extension of an assembled little-endian load buffer.
module mem_ld_extend
   import riscv_mem_pkg::*;
(
   input  logic [31:0] buf_data,
   input  logic [2:0]  ld,
   output logic [31:0] ext
);

   always_comb begin
      case (ld)
         LD_LB:   ext = {{24{buf_data[7]}}, buf_data[7:0]};
         LD_LH:   ext = {{16{buf_data[15]}}, buf_data[15:0]};
         LD_LBU:  ext = {24'h0, buf_data[7:0]};
         LD_LHU:  ext = {16'h0, buf_data[15:0]};
         default: ext = buf_data;
      endcase
   end

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrated byte-serial memory controller: IF fetch and MEM-stage data port onto an 8-bit sync RAM.
module mem_ctrl
   import riscv_mem_pkg::*;
#(
   parameter int RAM_AW = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [31:0]       if_addr_i,
   output logic [31:0]       if_data_o,
   output logic              if_done_o,
   output logic              if_busy_o,
   input  logic [2:0]        mem_read_i,
   input  logic [31:0]       mem_read_addr_i,
   input  logic [1:0]        mem_write_i,
   input  logic [31:0]       mem_write_addr_i,
   input  logic [31:0]       mem_write_data_i,
   output logic              read_busy_o,
   output logic              write_busy_o,
   output logic [31:0]       read_data_o,
   output logic              finish_o,
   input  logic [7:0]        ram_din_i,
   output logic [7:0]        ram_dout_o,
   output logic [RAM_AW-1:0] ram_a_o,
   output logic              ram_wr_o
);

   mem_state_t        state, state_nxt;
   mem_owner_t        owner;
   logic              is_st;
   logic [2:0]        ld_op;
   logic [1:0]        last;
   logic [1:0]        k;
   logic [RAM_AW-1:0] base;
   logic [31:0]       wdata;
   logic [31:0]       rbuf;
   logic [31:0]       ext;

   logic acc_st, acc_ld, acc_if, ld_valid;

   assign ld_valid = (mem_read_i >= LD_LB) && (mem_read_i <= LD_LHU);
   assign acc_st   = (mem_write_i != ST_NONE);
   assign acc_ld   = !acc_st && ld_valid;
   assign acc_if   = !acc_st && !ld_valid && if_req_i;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (acc_st || acc_ld || acc_if) state_nxt = S_XFER;
         S_XFER: if (k == last) state_nxt = is_st ? S_DONE : S_WAIT;
         S_WAIT: state_nxt = S_DONE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Access context and load assembly; a load captures the byte addressed one cycle earlier.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner <= OWN_IF;
         is_st <= 1'b0;
         ld_op <= LD_NONE;
         last  <= 2'd0;
         k     <= 2'd0;
         base  <= '0;
         wdata <= 32'h0;
         rbuf  <= 32'h0;
      end else begin
         case (state)
            S_IDLE: begin
               k    <= 2'd0;
               rbuf <= 32'h0;
               if (acc_st) begin
                  owner <= OWN_DATA;
                  is_st <= 1'b1;
                  last  <= st_last(mem_write_i);
                  base  <= mem_write_addr_i[RAM_AW-1:0];
                  wdata <= mem_write_data_i;
               end else if (acc_ld) begin
                  owner <= OWN_DATA;
                  is_st <= 1'b0;
                  ld_op <= mem_read_i;
                  last  <= ld_last(mem_read_i);
                  base  <= mem_read_addr_i[RAM_AW-1:0];
               end else if (acc_if) begin
                  owner <= OWN_IF;
                  is_st <= 1'b0;
                  ld_op <= LD_LW;
                  last  <= 2'd3;
                  base  <= if_addr_i[RAM_AW-1:0];
               end
            end
            S_XFER: begin
               k <= k + 2'd1;
               if (!is_st && k != 2'd0) rbuf[{k - 2'd1, 3'b000} +: 8] <= ram_din_i;
            end
            S_WAIT: rbuf[{last, 3'b000} +: 8] <= ram_din_i;
            default: ;
         endcase
      end
   end

   mem_ld_extend u_ext (
      .buf_data (rbuf),
      .ld       (owner == OWN_IF ? LD_LW : ld_op),
      .ext      (ext)
   );

   // Outputs are gated by rst so a reset mid-access stops writes and pulses in that same cycle.
   always_comb begin
      if_data_o    = 32'h0;
      if_done_o    = 1'b0;
      if_busy_o    = 1'b0;
      read_busy_o  = 1'b0;
      write_busy_o = 1'b0;
      read_data_o  = 32'h0;
      finish_o     = 1'b0;
      ram_dout_o   = 8'h0;
      ram_a_o      = '0;
      ram_wr_o     = 1'b0;
      if (!rst) begin
         case (state)
            S_XFER: begin
               ram_a_o      = base + RAM_AW'(k);
               ram_wr_o     = is_st;
               ram_dout_o   = is_st ? wdata[{k, 3'b000} +: 8] : 8'h0;
               read_busy_o  = 1'b1;
               write_busy_o = 1'b1;
               if_busy_o    = 1'b1;
            end
            S_WAIT: begin
               read_busy_o  = 1'b1;
               write_busy_o = 1'b1;
               if_busy_o    = 1'b1;
            end
            S_DONE: begin
               if (owner == OWN_IF) begin
                  if_done_o    = 1'b1;
                  if_data_o    = ext;
                  read_busy_o  = 1'b1;
                  write_busy_o = 1'b1;
               end else begin
                  finish_o    = 1'b1;
                  read_data_o = is_st ? 32'h0 : ext;
                  if_busy_o   = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte-wide synchronous RAM model.
module tb_mem_ctrl;
   import riscv_mem_pkg::*;

   localparam int AW = 17;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req_i;
   logic [31:0]   if_addr_i;
   logic [31:0]   if_data_o;
   logic          if_done_o, if_busy_o;
   logic [2:0]    mem_read_i;
   logic [31:0]   mem_read_addr_i;
   logic [1:0]    mem_write_i;
   logic [31:0]   mem_write_addr_i, mem_write_data_i;
   logic          read_busy_o, write_busy_o, finish_o;
   logic [31:0]   read_data_o;
   logic [7:0]    ram_din_i, ram_dout_o;
   logic [AW-1:0] ram_a_o;
   logic          ram_wr_o;

   always #5 clk = ~clk;

   mem_ctrl #(.RAM_AW(AW)) dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o),
      .if_done_o(if_done_o), .if_busy_o(if_busy_o),
      .mem_read_i(mem_read_i), .mem_read_addr_i(mem_read_addr_i),
      .mem_write_i(mem_write_i), .mem_write_addr_i(mem_write_addr_i),
      .mem_write_data_i(mem_write_data_i),
      .read_busy_o(read_busy_o), .write_busy_o(write_busy_o),
      .read_data_o(read_data_o), .finish_o(finish_o),
      .ram_din_i(ram_din_i), .ram_dout_o(ram_dout_o), .ram_a_o(ram_a_o), .ram_wr_o(ram_wr_o)
   );

   logic [7:0] ram [0:(1<<AW)-1];
   logic [7:0] ram_q;
   always @(posedge clk) begin
      if (ram_wr_o) ram[ram_a_o] <= ram_dout_o;
      ram_q <= ram[ram_a_o];
   end
   assign ram_din_i = ram_q;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   logic [AW-1:0] a_log [0:31];
   logic [7:0]    d_log [0:31];
   logic          wr_log[0:31];
   int            fin_cyc, ifd_cyc;
   logic [31:0]   rd_cap, ifd_cap;

   // Cycle 0 is the IDLE cycle in which the request is first presented.
   task automatic run_data(input logic [1:0] sw, input logic [2:0] ld,
                           input logic [31:0] addr, input logic [31:0] wd);
      mem_write_i = sw; mem_write_addr_i = addr; mem_write_data_i = wd;
      mem_read_i = ld;  mem_read_addr_i = addr;
      fin_cyc = -1;
      for (int c = 0; c < 32; c++) begin
         @(negedge clk);
         a_log[c] = ram_a_o; d_log[c] = ram_dout_o; wr_log[c] = ram_wr_o;
         if (finish_o) begin fin_cyc = c; rd_cap = read_data_o; end
         @(posedge clk); #1;
         if (fin_cyc >= 0) break;
      end
      mem_write_i = ST_NONE; mem_read_i = LD_NONE;
   endtask

   typedef struct {
      logic [1:0]  sw;
      logic [2:0]  ld;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vt[15];

   initial begin
      vt[0]  = '{ST_NONE, LD_LW,   32'h100, 32'h0,        32'hDEADBEEF, 6};
      vt[1]  = '{ST_SB,   LD_NONE, 32'h101, 32'h00000080, 32'h0,        2};
      vt[2]  = '{ST_NONE, LD_LB,   32'h101, 32'h0,        32'hFFFFFF80, 3};
      vt[3]  = '{ST_NONE, LD_LBU,  32'h101, 32'h0,        32'h00000080, 3};
      vt[4]  = '{ST_SW,   LD_NONE, 32'h200, 32'hCAFE8001, 32'h0,        5};
      vt[5]  = '{ST_NONE, LD_LH,   32'h200, 32'h0,        32'hFFFF8001, 4};
      vt[6]  = '{ST_NONE, LD_LHU,  32'h200, 32'h0,        32'h00008001, 4};
      vt[7]  = '{ST_NONE, LD_LW,   32'h100, 32'h0,        32'hDEAD80EF, 6};
      vt[8]  = '{ST_SW,   LD_LW,   32'h300, 32'h12345678, 32'h0,        5};
      vt[9]  = '{ST_NONE, LD_LW,   32'h300, 32'h0,        32'h12345678, 6};
      vt[10] = '{ST_SH,   LD_NONE, 32'h302, 32'hAAAA7FFF, 32'h0,        3};
      vt[11] = '{ST_NONE, LD_LW,   32'h300, 32'h0,        32'h7FFF5678, 6};
      vt[12] = '{ST_NONE, LD_LH,   32'h302, 32'h0,        32'h00007FFF, 4};
      vt[13] = '{ST_SW,   LD_NONE, 32'h400, 32'hA5A5A5A5, 32'h0,        5};
      vt[14] = '{ST_SW,   LD_NONE, 32'hFFFFFFFE, 32'hDDCCBBAA, 32'h0,   5};

      rst = 1'b1; if_req_i = 1'b0; if_addr_i = 32'h0;
      mem_read_i = LD_NONE; mem_read_addr_i = 32'h0;
      mem_write_i = ST_NONE; mem_write_addr_i = 32'h0; mem_write_data_i = 32'h0;

      // Reset, then idle: every output low.
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("reset_idle_outputs",
             {if_data_o, read_data_o, ram_dout_o, 7'(ram_a_o >> 10), ram_a_o[9:0]}, 64'h0);
         chk("reset_idle_flags",
             {59'h0, if_done_o, if_busy_o, read_busy_o | write_busy_o, finish_o, ram_wr_o}, 64'h0);
         if (c == 2) begin @(posedge clk); #1; rst = 1'b0; end
      end
      @(posedge clk); #1;

      // SW 0xDEADBEEF @0x100: bytes in cycles 1..4, finish in cycle 5.
      run_data(ST_SW, LD_NONE, 32'h100, 32'hDEADBEEF);
      chk("sw_finish_cycle", 64'(fin_cyc), 64'd5);
      chk("sw_cyc0_idle", {a_log[0], wr_log[0]}, 64'h0);
      chk("sw_addr", {a_log[1], a_log[2], a_log[3], a_log[4]},
          {17'h100, 17'h101, 17'h102, 17'h103});
      chk("sw_bytes", {d_log[1], d_log[2], d_log[3], d_log[4]}, 64'hEFBEADDE);
      chk("sw_wr", {wr_log[1], wr_log[2], wr_log[3], wr_log[4], wr_log[5]}, 64'b11110);

      foreach (vt[i]) begin
         run_data(vt[i].sw, vt[i].ld, vt[i].addr, vt[i].wd);
         chk($sformatf("vec%0d_latency", i), 64'(fin_cyc), 64'(vt[i].lat));
         if (vt[i].sw == ST_NONE)
            chk($sformatf("vec%0d_data", i), rd_cap, vt[i].exp);
      end

      // Reserved load encoding 6 is ignored.
      mem_read_i = 3'd6; mem_read_addr_i = 32'h100;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("ld6_ignored", {read_busy_o, if_busy_o, finish_o, ram_a_o}, 64'h0);
      end
      @(posedge clk); #1; mem_read_i = LD_NONE;

      // IF and data load in the same IDLE cycle: data first, IF afterwards.
      if_req_i = 1'b1; if_addr_i = 32'h200;
      mem_read_i = LD_LW; mem_read_addr_i = 32'h100;
      fin_cyc = -1; ifd_cyc = -1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (c == 3) chk("arb_if_busy", if_busy_o, 1'b1);
         if (finish_o) begin fin_cyc = c; rd_cap = read_data_o; end
         if (if_done_o) begin ifd_cyc = c; ifd_cap = if_data_o; end
         @(posedge clk); #1;
         if (fin_cyc == c) mem_read_i = LD_NONE;
         if (ifd_cyc == c) break;
      end
      if_req_i = 1'b0; mem_read_i = LD_NONE;
      chk("arb_data_finish", 64'(fin_cyc), 64'd6);
      chk("arb_data_value", rd_cap, 32'hDEAD80EF);
      chk("arb_if_done", 64'(ifd_cyc), 64'd13);
      chk("arb_if_value", ifd_cap, 32'hCAFE8001);

      // Data load arriving while an IF fetch is in progress.
      if_req_i = 1'b1; if_addr_i = 32'h200;
      fin_cyc = -1; ifd_cyc = -1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (c == 3) chk("late_read_busy_c3", read_busy_o, 1'b1);
         if (c == 6) chk("late_busy_if_done", {read_busy_o, write_busy_o, if_busy_o}, 3'b110);
         if (c == 7) chk("late_read_busy_idle", read_busy_o, 1'b0);
         if (finish_o) begin fin_cyc = c; rd_cap = read_data_o; end
         if (if_done_o) begin ifd_cyc = c; ifd_cap = if_data_o; end
         @(posedge clk); #1;
         if (c == 1) begin mem_read_i = LD_LW; mem_read_addr_i = 32'h100; end
         if (ifd_cyc == c) if_req_i = 1'b0;
         if (fin_cyc == c) break;
      end
      if_req_i = 1'b0; mem_read_i = LD_NONE;
      chk("late_if_done", 64'(ifd_cyc), 64'd6);
      chk("late_if_value", ifd_cap, 32'hCAFE8001);
      chk("late_data_finish", 64'(fin_cyc), 64'd13);
      chk("late_data_value", rd_cap, 32'hDEAD80EF);

      // rst during cycle 3 of SW 0x44332211 @0x400: only bytes 0..1 land.
      mem_write_i = ST_SW; mem_write_addr_i = 32'h400; mem_write_data_i = 32'h44332211;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         @(posedge clk); #1;
      end
      rst = 1'b1; mem_write_i = ST_NONE;
      @(negedge clk);
      chk("rst_mid_outputs", {ram_wr_o, finish_o, write_busy_o, if_busy_o}, 4'b0000);
      @(posedge clk); #1; rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("rst_then_idle", {finish_o, write_busy_o, if_busy_o, ram_wr_o}, 4'b0000);
      end
      chk("rst_bytes", {ram[17'h400], ram[17'h401], ram[17'h402], ram[17'h403]}, 32'h1122A5A5);
      @(posedge clk); #1;

      // LW @0xFFFFFFFE wraps through the top of the address space to 0x0/0x1.
      run_data(ST_NONE, LD_LW, 32'hFFFFFFFE, 32'h0);
      chk("wrap_latency", 64'(fin_cyc), 64'd6);
      chk("wrap_data", rd_cap, 32'hDDCCBBAA);
      chk("wrap_addr", {a_log[1], a_log[2], a_log[3], a_log[4]},
          {17'h1FFFE, 17'h1FFFF, 17'h00000, 17'h00001});
      chk("wrap_no_wr", {wr_log[1], wr_log[2], wr_log[3], wr_log[4]}, 4'b0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller between the pipeline and the 8-bit synchronous RAM bus. Arbitrates between instruction fetch (IF port) and the MEM stage data port, serialises 1/2/4-byte accesses into little-endian byte transfers, and sign/zero-extends loads. Presents the busy/finish handshake the MEM stage stalls on.

## Interface
- `RAM_AW`, default 17, RAM address width; `ram_a_o` carries the low `RAM_AW` bits of the byte address.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `if_req_i` in 1: fetch request, level; held until `if_done_o`.
- `if_addr_i` in 32: fetch byte address.
- `if_data_o` out 32: fetched word; valid when `if_done_o`.
- `if_done_o` out 1: one-cycle fetch completion pulse.
- `if_busy_o` out 1: controller not available to IF.
- `mem_read_i` in 3: load type: 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU.
- `mem_read_addr_i` in 32: load byte address.
- `mem_write_i` in 2: store type: 0 none, 1 SB, 2 SH, 3 SW.
- `mem_write_addr_i` in 32: store byte address.
- `mem_write_data_i` in 32: store data; the low N bytes are used.
- `read_busy_o` out 1: data load in flight or controller occupied.
- `write_busy_o` out 1: data store in flight or controller occupied.
- `read_data_o` out 32: extended load result; valid when `finish_o`.
- `finish_o` out 1: one-cycle data access completion pulse.
- `ram_din_i` in 8: RAM read byte; 1-cycle synchronous read latency.
- `ram_dout_o` out 8: RAM write byte.
- `ram_a_o` out RAM_AW: RAM byte address.
- `ram_wr_o` out 1: RAM write strobe.

## Operation
- FSM states: IDLE, XFER, WAIT, DONE. Registers: owner (IF/DATA), op, base addr, wdata, byte counter k (0..3), 32-bit assembly buffer.
- IDLE: requests are sampled here only. Priority: data store > data load > IF. If `mem_write_i` and `mem_read_i` are both nonzero, the store wins and the load is ignored. Encodings 6/7 on `mem_read_i` are treated as none. On accept, latch owner, op, address, and data; set N = 1/2/4; go to XFER with k=0.
- XFER, N cycles: `ram_a_o` = (base+k) truncated to `RAM_AW`, with 32-bit wrap. Stores drive `ram_wr_o`=1 and `ram_dout_o` = byte k. Loads drive `ram_wr_o`=0, and the byte requested in the previous cycle is captured into buffer byte k-1. After the cycle with k=N-1: stores go to DONE, loads go to WAIT.
- WAIT, loads only: capture the last byte into buffer byte N-1, then go to DONE.
- DONE, 1 cycle: the owner's completion pulse is high.
  - Loads: `read_data_o`/`if_data_o` = buffer extended. LB sign-extends from bit 7, LH from bit 15. LBU/LHU zero-extend. LW is passed unchanged. IF is always LW.
  - Return to IDLE. Requests asserted during DONE are ignored. Requesters must drop their request in the cycle after the pulse.
- Busy: `read_busy_o` = `write_busy_o` = 1 in XFER/WAIT, and in DONE when owner = IF. Both are 0 in IDLE and in data-owned DONE. `if_busy_o` = 1 in every non-IDLE state except IF-owned DONE.
- An IF access in progress is never preempted; a data request waits, seeing busy=1.
- `ram_wr_o`=0 and `ram_a_o`=0 in IDLE, WAIT, and DONE.

## Timing
- Reset values: every output is 0, FSM = IDLE, buffer = 0.
- `rst` mid-access: IDLE on the next edge; pulses are suppressed. Bytes already written stay written.
- Request sampled at the end of cycle 0. Bytes go out in cycles 1..N. Load data arrives in cycles 2..N+1.
- Load: `finish_o` in cycle N+2. LW → cycle 6, LB → cycle 3.
- Store: finish in cycle N+1. SW → cycle 5, SB → cycle 2.
- Back-to-back: next request accepted no earlier than the cycle after DONE.

## Structure
- Shared package `riscv_mem_pkg` holds:
  - load/store encoding constants (`LD_NONE`..`LD_LHU`, `ST_NONE`..`ST_SW`);
  - the FSM state enum;
  - an owner enum.
  - The MEM stage imports the same encodings.
- One combinational sub-module, `mem_ld_extend`: 32-bit buffer + load type → extended word.

## Test plan
- Reset, then idle: all outputs 0; `ram_wr_o` never high.
- SW 0xDEADBEEF @0x100, then LW @0x100:
  - writes EF,BE,AD,DE to 0x100..0x103 in cycles 1–4; `finish_o` in cycle 5;
  - load returns 0xDEADBEEF with finish in cycle 6.
- LB, then LBU @0x101 holding 0x80: `read_data_o` = 0xFFFFFF80, then 0x00000080. LH of 0x8001 → 0xFFFF8001.
- IF and data load requested in the same IDLE cycle: data served first, with `if_busy_o`=1. IF then completes with `if_done_o` 6 cycles after its acceptance.
- Data request arriving during an IF fetch: `read_busy_o`=1 until the IF DONE cycle. Data is then accepted next IDLE, and `if_data_o` is uncorrupted.
- `rst` asserted during cycle 3 of SW: only bytes 0–1 written. No `finish_o`, FSM IDLE next cycle. A subsequent LW @0xFFFFFFFE wraps to 0x0/0x1.
